// File: rtl/bullet_pool.sv
// bullet_pool
// Multi-shot projectile engine for one player, clocked once per video frame.
// A pool of NUM_BULLETS slots is fed by an edge-triggered fire key with a frame
// cooldown; active bullets travel in the direction the player faced when they
// were fired and retire at the playfield edge or on a kill strobe.
//
// Ports:
//   frame_clk          frame-rate clock, all state changes on its rising edge
//   Reset              asynchronous, active-high
//   direction[1:0]     player facing: 00 left, 01 right, 10 down, 11 up
//   keycode[7:0]       current keyboard code
//   PlayerX/PlayerY    player centre, 10 bits each
//   upgraded           speed powerup active (adds BOOST to each move)
//   kill[N-1:0]        per-slot barrier/player-hit strobe
//   BulletX/BulletY    packed slot positions, slot i at bits [10i+9:10i]
//   BulletS            constant bullet half-size
//   bullet_on[N-1:0]   slot active flags
//   fire_pulse         high for the frame after a shot is accepted
module bullet_pool #(
  parameter int         NUM_BULLETS = 4,
  parameter logic [7:0] FIRE_KEY    = 8'd88,
  parameter int         STEP        = 12,
  parameter int         BOOST       = 6,
  parameter int         COOLDOWN    = 8,
  parameter int         SIZE        = 4,
  parameter int         X_MIN       = 1,
  parameter int         X_MAX       = 639,
  parameter int         Y_MIN       = 1,
  parameter int         Y_MAX       = 479
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [1:0]                direction,
  input  logic [7:0]                keycode,
  input  logic [9:0]                PlayerX,
  input  logic [9:0]                PlayerY,
  input  logic                      upgraded,
  input  logic [NUM_BULLETS-1:0]    kill,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [9:0]                BulletS,
  output logic [NUM_BULLETS-1:0]    bullet_on,
  output logic                      fire_pulse
);

  // A zero cooldown still needs a one-bit counter so the port widths stay legal.
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  localparam logic signed [10:0] SStep  = 11'(STEP);
  localparam logic signed [10:0] SBoost = 11'(BOOST);
  localparam logic signed [10:0] SSize  = 11'(SIZE);
  localparam logic signed [10:0] SXMin  = 11'(X_MIN);
  localparam logic signed [10:0] SXMax  = 11'(X_MAX);
  localparam logic signed [10:0] SYMin  = 11'(Y_MIN);
  localparam logic signed [10:0] SYMax  = 11'(Y_MAX);

  logic [NUM_BULLETS-1:0] r_active;
  logic [1:0]             r_dir [NUM_BULLETS];
  logic [9:0]             r_x   [NUM_BULLETS];
  logic [9:0]             r_y   [NUM_BULLETS];
  logic                   r_keyReleased;
  logic [CW-1:0]          r_cooldown;
  logic                   r_firePulse;

  logic signed [10:0]     w_speed;
  logic signed [10:0]     w_sx    [NUM_BULLETS];
  logic signed [10:0]     w_sy    [NUM_BULLETS];
  logic [9:0]             w_nextX [NUM_BULLETS];
  logic [9:0]             w_nextY [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] w_retire;
  logic                   w_anyFree;
  logic [IW-1:0]          w_allocIdx;
  logic                   w_accept;

  // Saturate a signed 11-bit coordinate into [lo, hi] so a bullet never wraps.
  function automatic logic [9:0] clampAxis(input logic signed [10:0] v,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi);
    logic [9:0] res;
    if (v < lo)      res = lo[9:0];
    else if (v > hi) res = hi[9:0];
    else             res = v[9:0];
    return res;
  endfunction

  always_comb begin
    w_speed = upgraded ? (SStep + SBoost) : SStep;
  end

  // Per-slot retire test and next position. Coordinates are widened to signed
  // 11 bits so X-SIZE near zero goes negative instead of wrapping high.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      w_sx[i]     = $signed({1'b0, r_x[i]});
      w_sy[i]     = $signed({1'b0, r_y[i]});
      w_retire[i] = r_active[i] &&
                    ((w_sy[i] + SSize >= SYMax) || (w_sy[i] - SSize <= SYMin) ||
                     (w_sx[i] + SSize >= SXMax) || (w_sx[i] - SSize <= SXMin) ||
                     kill[i]);
      w_nextX[i]  = r_x[i];
      w_nextY[i]  = r_y[i];
      case (r_dir[i])
        2'b00:   w_nextX[i] = clampAxis(w_sx[i] - w_speed, SXMin, SXMax);
        2'b01:   w_nextX[i] = clampAxis(w_sx[i] + w_speed, SXMin, SXMax);
        2'b10:   w_nextY[i] = clampAxis(w_sy[i] + w_speed, SYMin, SYMax);
        default: w_nextY[i] = clampAxis(w_sy[i] - w_speed, SYMin, SYMax);
      endcase
    end
  end

  // Lowest-index free slot, scanning downward so the last hit is the lowest.
  // Uses registered active, so a slot retiring this frame is not yet free.
  always_comb begin
    w_anyFree  = 1'b0;
    w_allocIdx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_anyFree  = 1'b1;
        w_allocIdx = IW'(i);
      end
    end
  end

  always_comb begin
    w_accept = (keycode == FIRE_KEY) && r_keyReleased &&
               (r_cooldown == '0) && w_anyFree;
  end

  // Slot and global state. Idle slots shadow the player so a fresh bullet
  // already sits on the player when it is allocated.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_active      <= '0;
      r_keyReleased <= 1'b1;
      r_cooldown    <= '0;
      r_firePulse   <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        r_dir[i] <= 2'b00;
        r_x[i]   <= '0;
        r_y[i]   <= '0;
      end
    end else begin
      r_keyReleased <= (keycode != FIRE_KEY);
      r_firePulse   <= w_accept;
      if (w_accept)
        r_cooldown <= CW'(COOLDOWN);
      else if (r_cooldown != '0)
        r_cooldown <= r_cooldown - 1'b1;

      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (w_accept && (w_allocIdx == IW'(i))) begin
          r_active[i] <= 1'b1;
          r_dir[i]    <= direction;
          r_x[i]      <= PlayerX;
          r_y[i]      <= PlayerY;
        end else if (r_active[i]) begin
          if (w_retire[i]) begin
            r_active[i] <= 1'b0;
          end else begin
            r_x[i] <= w_nextX[i];
            r_y[i] <= w_nextY[i];
          end
        end else begin
          r_x[i] <= PlayerX;
          r_y[i] <= PlayerY;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BULLETS; g++) begin : gPack
      assign BulletX[10*g +: 10] = r_x[g];
      assign BulletY[10*g +: 10] = r_y[g];
    end
  endgenerate

  assign BulletS    = 10'(SIZE);
  assign bullet_on  = r_active;
  assign fire_pulse = r_firePulse;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool
// Drives bullet_pool (default parameters) through directed scenarios with
// hand-computed expectations, then a long randomized run. A frame-level model
// of the pool is updated on every rising edge and compared against every DUT
// output on every falling edge.
module tb_bullet_pool;

  localparam int N = 4;

  logic            frame_clk = 1'b0;
  logic            Reset;
  logic [1:0]      direction;
  logic [7:0]      keycode;
  logic [9:0]      PlayerX;
  logic [9:0]      PlayerY;
  logic            upgraded;
  logic [N-1:0]    kill;
  logic [10*N-1:0] BulletX;
  logic [10*N-1:0] BulletY;
  logic [9:0]      BulletS;
  logic [N-1:0]    bullet_on;
  logic            fire_pulse;

  int checks   = 0;
  int failures = 0;

  bullet_pool dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .direction (direction),
    .keycode   (keycode),
    .PlayerX   (PlayerX),
    .PlayerY   (PlayerY),
    .upgraded  (upgraded),
    .kill      (kill),
    .BulletX   (BulletX),
    .BulletY   (BulletY),
    .BulletS   (BulletS),
    .bullet_on (bullet_on),
    .fire_pulse(fire_pulse)
  );

  always #5 frame_clk = ~frame_clk;

  // Frame-level model: plain integers, one entry per slot.
  bit mActive [N];
  int mDir    [N];
  int mX      [N];
  int mY      [N];
  bit mKeyRel;
  int mCool;
  bit mPulse;

  function automatic bit offField(input int x, input int y);
    return (y + 4 >= 479) || (y - 4 <= 1) || (x + 4 >= 639) || (x - 4 <= 1);
  endfunction

  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  always @(posedge frame_clk or posedge Reset) begin : modelUpdate
    int  freeSlot;
    bit  accept;
    int  sp;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        mActive[i] = 1'b0; mDir[i] = 0; mX[i] = 0; mY[i] = 0;
      end
      mKeyRel = 1'b1; mCool = 0; mPulse = 1'b0;
    end else begin
      freeSlot = -1;
      for (int i = 0; i < N; i++)
        if (!mActive[i] && freeSlot < 0) freeSlot = i;
      accept = (keycode == 8'd88) && mKeyRel && (mCool == 0) && (freeSlot >= 0);
      sp = upgraded ? 18 : 12;
      for (int i = 0; i < N; i++) begin
        if (accept && i == freeSlot) begin
          mActive[i] = 1'b1; mDir[i] = int'(direction);
          mX[i] = int'(PlayerX); mY[i] = int'(PlayerY);
        end else if (mActive[i]) begin
          if (offField(mX[i], mY[i]) || kill[i]) begin
            mActive[i] = 1'b0;
          end else begin
            case (mDir[i])
              0: mX[i] = clampInt(mX[i] - sp, 1, 639);
              1: mX[i] = clampInt(mX[i] + sp, 1, 639);
              2: mY[i] = clampInt(mY[i] + sp, 1, 479);
              default: mY[i] = clampInt(mY[i] - sp, 1, 479);
            endcase
          end
        end else begin
          mX[i] = int'(PlayerX); mY[i] = int'(PlayerY);
        end
      end
      mCool   = accept ? 8 : ((mCool > 0) ? mCool - 1 : 0);
      mKeyRel = (keycode != 8'd88);
      mPulse  = accept;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge frame_clk) begin
    int onVec;
    onVec = 0;
    for (int i = 0; i < N; i++) onVec |= (int'(mActive[i]) << i);
    checkOutput("model bullet_on", int'(bullet_on), onVec);
    checkOutput("model fire_pulse", int'(fire_pulse), int'(mPulse));
    checkOutput("model BulletS", int'(BulletS), 4);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("model BulletX[%0d]", i), int'(BulletX[10*i +: 10]), mX[i]);
      checkOutput($sformatf("model BulletY[%0d]", i), int'(BulletY[10*i +: 10]), mY[i]);
    end
  end

  task automatic applyStimulus(input logic [7:0] kc, input logic [1:0] dirv,
                               input logic [9:0] px, input logic [9:0] py,
                               input logic upg, input logic [N-1:0] kv);
    keycode = kc; direction = dirv; PlayerX = px; PlayerY = py;
    upgraded = upg; kill = kv;
  endtask

  // One frame: wait for the active edge, then settle away from it.
  task automatic tick();
    @(posedge frame_clk);
    #2;
  endtask

  task automatic idle(input int n);
    keycode = 8'd0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic shoot();
    keycode = 8'd88;
    tick();
    keycode = 8'd0;
  endtask

  task automatic pulseReset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(8'd0, 2'b01, 10'd320, 10'd240, 1'b0, '0);
    #12;
    Reset = 1'b0;
    checkOutput("reset bullet_on", int'(bullet_on), 0);
    checkOutput("reset fire_pulse", int'(fire_pulse), 0);
    checkOutput("reset X0", int'(BulletX[9:0]), 0);

    // Held key fires once; bullet moves right by 12 per frame.
    keycode = 8'd88;
    tick();
    checkOutput("fire bullet_on", int'(bullet_on), 1);
    checkOutput("fire X0", int'(BulletX[9:0]), 320);
    checkOutput("fire Y0", int'(BulletY[9:0]), 240);
    checkOutput("fire pulse", int'(fire_pulse), 1);
    tick();
    checkOutput("move1 X0", int'(BulletX[9:0]), 332);
    checkOutput("move1 pulse", int'(fire_pulse), 0);
    tick();
    checkOutput("move2 X0", int'(BulletX[9:0]), 344);
    checkOutput("held one slot", int'(bullet_on), 1);
    keycode = 8'd0;

    // Boosted left shot from X=100 saturates at 1 and then retires.
    pulseReset();
    applyStimulus(8'd88, 2'b00, 10'd100, 10'd240, 1'b1, '0);
    tick();
    checkOutput("left fire X0", int'(BulletX[9:0]), 100);
    keycode = 8'd0;
    tick(); checkOutput("left X0 82", int'(BulletX[9:0]), 82);
    tick(); checkOutput("left X0 64", int'(BulletX[9:0]), 64);
    tick(); checkOutput("left X0 46", int'(BulletX[9:0]), 46);
    tick(); checkOutput("left X0 28", int'(BulletX[9:0]), 28);
    tick(); checkOutput("left X0 10", int'(BulletX[9:0]), 10);
    tick();
    checkOutput("left clamp X0", int'(BulletX[9:0]), 1);
    checkOutput("left clamp on", int'(bullet_on), 1);
    tick();
    checkOutput("left retire on", int'(bullet_on), 0);
    tick();
    checkOutput("idle follows player", int'(BulletX[9:0]), 100);

    // Cooldown refusal, then kill and fire in the same frame.
    pulseReset();
    applyStimulus(8'd0, 2'b10, 10'd320, 10'd240, 1'b0, '0);
    shoot();
    idle(3);
    shoot();
    checkOutput("cooldown refused on", int'(bullet_on), 1);
    checkOutput("cooldown refused pulse", int'(fire_pulse), 0);
    idle(4);
    kill = 4'b0001;
    shoot();
    kill = '0;
    checkOutput("kill+fire on", int'(bullet_on), 2);
    checkOutput("kill+fire pulse", int'(fire_pulse), 1);
    checkOutput("kill+fire Y1", int'(BulletY[19:10]), 240);

    // Fill the pool, refuse when full, reuse a killed slot.
    pulseReset();
    applyStimulus(8'd0, 2'b00, 10'd600, 10'd240, 1'b0, '0);
    shoot(); checkOutput("alloc slot0", int'(bullet_on), 1);
    idle(8);
    shoot(); checkOutput("alloc slot1", int'(bullet_on), 3);
    idle(8);
    shoot(); checkOutput("alloc slot2", int'(bullet_on), 7);
    idle(8);
    shoot(); checkOutput("alloc slot3", int'(bullet_on), 15);
    idle(8);
    shoot();
    checkOutput("full refused on", int'(bullet_on), 15);
    checkOutput("full refused pulse", int'(fire_pulse), 0);
    kill = 4'b0010;
    tick();
    kill = '0;
    checkOutput("kill slot1", int'(bullet_on), 13);
    shoot();
    checkOutput("reuse slot1", int'(bullet_on), 15);
    checkOutput("reuse X1", int'(BulletX[19:10]), 600);
    kill = 4'b1000;
    tick();
    kill = '0;
    checkOutput("three active", int'(bullet_on), 7);

    // Asynchronous reset mid-flight clears everything at once.
    Reset = 1'b1;
    #1;
    checkOutput("midflight reset on", int'(bullet_on), 0);
    checkOutput("midflight reset pulse", int'(fire_pulse), 0);
    checkOutput("midflight reset X", int'(BulletX), 0);
    checkOutput("midflight reset Y", int'(BulletY), 0);
    Reset = 1'b0;
    shoot();
    checkOutput("cooldown cleared", int'(bullet_on), 1);

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 2) == 0) ? 8'd88 : 8'($urandom_range(0, 255)),
                    2'($urandom_range(0, 3)),
                    10'($urandom_range(0, 700)), 10'($urandom_range(0, 500)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
      if ($urandom_range(0, 499) == 0) pulseReset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
